// File: rtl/prng_histogram_pkg.sv
// Shared types, default bin table and the lowest-index bin matcher for the
// PRNG occurrence histogram.
package prng_histogram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DUMP  = 2'd2
    } state_t;

    localparam int MAX_DATA_W = 32;
    localparam int MAX_BINS   = 64;
    localparam int MAX_VEC_W  = MAX_DATA_W * MAX_BINS;

    // Bin 0 sits in the least significant slice.
    localparam logic [159:0] DEFAULT_BIN_VALUES = {
        16'h0800, 16'h071C, 16'h0638, 16'h0555, 16'h0471,
        16'h038E, 16'h02AA, 16'h01C7, 16'h00E3, 16'h0000
    };

    typedef struct packed {
        logic       hit;
        logic [7:0] index;
    } bin_match_t;

    // Scanning from the top down lets the lowest matching index win.
    function automatic bin_match_t bin_match(
        input logic [MAX_DATA_W-1:0] data,
        input logic [MAX_VEC_W-1:0]  values,
        input int                    num_bins,
        input int                    data_w
    );
        bin_match_t            res;
        logic [MAX_DATA_W-1:0] mask;
        logic [MAX_VEC_W-1:0]  shifted;
        res  = '0;
        mask = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - data_w);
        for (int i = MAX_BINS - 1; i >= 0; i--) begin
            shifted = values >> (i * data_w);
            if ((i < num_bins) && ((shifted[MAX_DATA_W-1:0] & mask) == (data & mask))) begin
                res.hit   = 1'b1;
                res.index = i[7:0];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prng_histogram_sat_counter.sv
// Saturating up-counter with synchronous clear; one instance per histogram
// bin, one for the miss bin and one for the sample count.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Count register: clear wins over increment, all-ones holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + CNT_W'(1);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/prng_histogram.sv
// Occurrence histogram of a valid-qualified sample stream over programmed
// bin values plus a miss bin, read out over a ready/valid port.
module prng_histogram
    import prng_histogram_pkg::*;
#(
    parameter int                         DATA_W     = 16,
    parameter int                         NUM_BINS   = 10,
    parameter int                         CNT_W      = 32,
    parameter int                         WINDOW     = 32,
    parameter logic [NUM_BINS*DATA_W-1:0] BIN_VALUES = DEFAULT_BIN_VALUES
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            in_valid,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            busy,
    output logic                            done,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [$clog2(NUM_BINS+1)-1:0]   rd_index,
    output logic [CNT_W-1:0]                rd_count,
    output logic                            rd_last
);

    localparam int               IDX_W   = $clog2(NUM_BINS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                state_r;
    state_t                state_s;
    logic [MAX_DATA_W-1:0] data_ext_s;
    logic [MAX_VEC_W-1:0]  values_ext_s;
    bin_match_t            match_s;
    logic                  accept_s;
    logic                  clr_s;
    logic                  win_hit_s;
    logic                  to_dump_s;
    logic                  last_hs_s;
    logic [NUM_BINS:0]     inc_s;
    logic [CNT_W-1:0]      cnt_s      [NUM_BINS+1];
    logic [CNT_W-1:0]      cnt_next_s [NUM_BINS+1];
    logic [CNT_W-1:0]      sample_cnt_s;
    logic [IDX_W-1:0]      rd_sel_s;
    logic [CNT_W-1:0]      mux_count_s;
    logic                  busy_r;
    logic                  done_r;
    logic                  rd_valid_r;
    logic                  rd_last_r;
    logic [IDX_W-1:0]      rd_index_r;
    logic [CNT_W-1:0]      rd_count_r;

    // Widen sample and bin table to the matcher's fixed operand widths.
    always_comb begin
        data_ext_s                           = '0;
        data_ext_s[DATA_W-1:0]               = in_data;
        values_ext_s                         = '0;
        values_ext_s[NUM_BINS*DATA_W-1:0]    = BIN_VALUES;
        match_s = bin_match(data_ext_s, values_ext_s, NUM_BINS, DATA_W);
    end

    assign accept_s  = (state_r == COUNT) && in_valid;
    assign clr_s     = (state_r == IDLE) && start;
    // Compare one bit wider so the sample about to be accepted is included.
    assign win_hit_s = (WINDOW != 0) && accept_s &&
                       (({1'b0, sample_cnt_s} + (CNT_W+1)'(1)) == (CNT_W+1)'(WINDOW));
    assign to_dump_s = (state_r == COUNT) && (stop || win_hit_s);
    assign last_hs_s = (state_r == DUMP) && rd_valid_r && rd_ready && rd_last_r;

    // One-hot increment for the matched bin, or the miss bin.
    always_comb begin
        inc_s = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            inc_s[i] = accept_s && match_s.hit && (match_s.index == 8'(i));
        end
        inc_s[NUM_BINS] = accept_s && !match_s.hit;
    end

    for (genvar g = 0; g <= NUM_BINS; g++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr_s),
            .inc (inc_s[g]),
            .q   (cnt_s[g])
        );
        // Look-ahead value so the first readout entry sees the final sample.
        assign cnt_next_s[g] = (inc_s[g] && (cnt_s[g] != CNT_MAX)) ? cnt_s[g] + CNT_W'(1) : cnt_s[g];
    end

    sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .inc (accept_s),
        .q   (sample_cnt_s)
    );

    // Select the counter for the entry to be loaded at the next edge.
    always_comb begin
        rd_sel_s    = (state_r == DUMP) ? rd_index_r + IDX_W'(1) : '0;
        mux_count_s = '0;
        for (int i = 0; i <= NUM_BINS; i++) begin
            mux_count_s = (rd_sel_s == IDX_W'(i)) ? cnt_next_s[i] : mux_count_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = clr_s ? COUNT : IDLE;
            COUNT:   state_s = to_dump_s ? DUMP : COUNT;
            DUMP:    state_s = last_hs_s ? IDLE : DUMP;
            default: state_s = IDLE;
        endcase
    end

    // State register plus registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= last_hs_s;
        end
    end

    // Readout entry registers: load on entry to DUMP and after each handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r <= 1'b0;
            rd_index_r <= '0;
            rd_count_r <= '0;
            rd_last_r  <= 1'b0;
        end else if (to_dump_s || (rd_valid_r && rd_ready && !rd_last_r)) begin
            rd_valid_r <= 1'b1;
            rd_index_r <= rd_sel_s;
            rd_count_r <= mux_count_s;
            rd_last_r  <= (rd_sel_s == IDX_W'(NUM_BINS));
        end else if (last_hs_s) begin
            rd_valid_r <= 1'b0;
            rd_index_r <= '0;
            rd_count_r <= '0;
            rd_last_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_valid_r;
            rd_index_r <= rd_index_r;
            rd_count_r <= rd_count_r;
            rd_last_r  <= rd_last_r;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rd_valid = rd_valid_r;
    assign rd_index = rd_index_r;
    assign rd_count = rd_count_r;
    assign rd_last  = rd_last_r;

endmodule

// File: tb/tb_prng_histogram.sv
// Scoreboard bench: two histogram instances (windowed/default bins and
// free-running/3-bit/duplicate bins) share one stimulus stream.
module tb_prng_histogram;

    localparam int NB = 10;
    localparam logic [159:0] BINS_W = {16'h0800, 16'h071C, 16'h0638, 16'h0555, 16'h0471,
                                       16'h038E, 16'h02AA, 16'h01C7, 16'h00E3, 16'h0000};
    localparam logic [159:0] BINS_F = {16'h0800, 16'h071C, 16'h0638, 16'h0AAA, 16'h0555,
                                       16'h038E, 16'h02AA, 16'h0555, 16'h00E3, 16'h0000};

    logic        clk = 1'b0;
    logic        rst, start, stop, in_valid, rd_ready;
    logic [15:0] in_data;

    logic        w_busy, w_done, w_rd_valid, w_rd_last;
    logic [3:0]  w_rd_index;
    logic [31:0] w_rd_count;
    logic        f_busy, f_done, f_rd_valid, f_rd_last;
    logic [3:0]  f_rd_index;
    logic [2:0]  f_rd_count;

    prng_histogram #(.DATA_W(16), .NUM_BINS(NB), .CNT_W(32), .WINDOW(4), .BIN_VALUES(BINS_W)) u_win (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .in_data(in_data),
        .busy(w_busy), .done(w_done), .rd_valid(w_rd_valid), .rd_ready(rd_ready),
        .rd_index(w_rd_index), .rd_count(w_rd_count), .rd_last(w_rd_last));

    prng_histogram #(.DATA_W(16), .NUM_BINS(NB), .CNT_W(3), .WINDOW(0), .BIN_VALUES(BINS_F)) u_free (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .in_data(in_data),
        .busy(f_busy), .done(f_done), .rd_valid(f_rd_valid), .rd_ready(rd_ready),
        .rd_index(f_rd_index), .rd_count(f_rd_count), .rd_last(f_rd_last));

    always #5 clk = ~clk;

    logic        busy_o [2];
    logic        done_o [2];
    logic        rv_o   [2];
    logic        last_o [2];
    logic [3:0]  idx_o  [2];
    logic [31:0] cnt_o  [2];
    assign busy_o[0] = w_busy;     assign busy_o[1] = f_busy;
    assign done_o[0] = w_done;     assign done_o[1] = f_done;
    assign rv_o[0]   = w_rd_valid; assign rv_o[1]   = f_rd_valid;
    assign last_o[0] = w_rd_last;  assign last_o[1] = f_rd_last;
    assign idx_o[0]  = w_rd_index; assign idx_o[1]  = f_rd_index;
    assign cnt_o[0]  = w_rd_count; assign cnt_o[1]  = {29'd0, f_rd_count};

    typedef struct {
        int          index;
        logic [31:0] count;
        logic        last;
    } entry_t;

    entry_t      exp_q [2][$];
    int          n_vec = 0;
    int          n_err = 0;
    int          bins_tab   [2][NB];
    int          window_tab [2];
    longint      cmax_tab   [2];
    int          rdy_mode = 3;

    bit          s_valid [$];
    logic [15:0] s_data  [$];
    bit          s_stop  [$];
    bit          s_start [$];

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] snap(input int d);
        return {busy_o[d], done_o[d], rv_o[d], idx_o[d], cnt_o[d], last_o[d]};
    endfunction

    // Reference model: walk the cycle list, count matches by lowest index,
    // saturate at the counter ceiling, stop on stop or the WINDOW-th sample.
    function automatic void push_expected(input int d);
        longint cnt [NB+1];
        int     n;
        entry_t e;
        n = 0;
        for (int i = 0; i <= NB; i++) cnt[i] = 0;
        for (int c = 0; c < s_valid.size(); c++) begin
            if (s_valid[c]) begin
                int hit;
                hit = NB;
                for (int i = NB - 1; i >= 0; i--) if (bins_tab[d][i] == int'(s_data[c])) hit = i;
                if (cnt[hit] < cmax_tab[d]) cnt[hit]++;
                n++;
            end
            if (s_stop[c] || (window_tab[d] != 0 && s_valid[c] && n == window_tab[d])) break;
        end
        for (int i = 0; i <= NB; i++) begin
            e.index = i;
            e.count = cnt[i][31:0];
            e.last  = (i == NB);
            exp_q[d].push_back(e);
        end
    endfunction

    task automatic clear_stream();
        s_valid.delete(); s_data.delete(); s_stop.delete(); s_start.delete();
    endtask

    task automatic add(input bit v, input logic [15:0] dat, input bit st, input bit sa);
        s_valid.push_back(v); s_data.push_back(dat); s_stop.push_back(st); s_start.push_back(sa);
    endtask

    task automatic drive_stream();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < s_valid.size(); c++) begin
            in_valid = s_valid[c]; in_data = s_data[c]; stop = s_stop[c]; start = s_start[c];
            @(posedge clk); #1;
        end
        in_valid = 1'b0; stop = 1'b0; start = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 400;
        while ((busy_o[0] || busy_o[1] || exp_q[0].size() != 0 || exp_q[1].size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("drain_busy", 0, {62'd0, busy_o[0], busy_o[1]}, 64'd0);
        check("drain_queue", 0, 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
        exp_q[0].delete(); exp_q[1].delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_meas(input int mode);
        push_expected(0);
        push_expected(1);
        rdy_mode = mode;
        drive_stream();
        wait_idle();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) check("reset_outputs", d, 64'(snap(d)), 64'd0);
        rst = 1'b0;
        exp_q[0].delete(); exp_q[1].delete();
    endtask

    // Ready pattern generator.
    initial begin
        int k;
        logic [3:0] pat;
        pat = 4'b1001;
        k = 0;
        rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: rd_ready = 1'b1;
                1: begin rd_ready = pat[3 - (k % 4)]; k++; end
                2: rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pop and compare on each handshake, hold-check stalls, check done.
    logic [37:0] held [2];
    bit          stall [2];
    bit          exp_done [2];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            entry_t e;
            if (rst) begin
                stall[d] = 1'b0;
                exp_done[d] = 1'b0;
            end else begin
                if (exp_done[d]) check("done_pulse", d, {62'd0, done_o[d], busy_o[d]}, 64'd2);
                else check("no_stray_done", d, {63'd0, done_o[d]}, 64'd0);
                exp_done[d] = 1'b0;
                if (stall[d]) check("stall_hold", d, 64'(snap(d) & 40'hFF_FFFF_FFFF) & 64'h3F_FFFF_FFFF, 64'(held[d]));
                if (rv_o[d] && rd_ready) begin
                    if (exp_q[d].size() == 0) begin
                        check("unexpected_entry", d, {60'd0, idx_o[d]}, 64'hFFFF);
                    end else begin
                        e = exp_q[d].pop_front();
                        check("rd_index", d, {60'd0, idx_o[d]}, 64'(e.index));
                        check($sformatf("rd_count_idx%0d", e.index), d, {32'd0, cnt_o[d]}, {32'd0, e.count});
                        check("rd_last", d, {63'd0, last_o[d]}, {63'd0, e.last});
                        exp_done[d] = e.last;
                    end
                end
                stall[d] = rv_o[d] && !rd_ready;
                held[d]  = snap(d)[37:0];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] tmp;
        logic [15:0]  dat;
        int           len;
        tmp = BINS_W;
        for (int i = 0; i < NB; i++) bins_tab[0][i] = int'(tmp[i*16 +: 16]);
        tmp = BINS_F;
        for (int i = 0; i < NB; i++) bins_tab[1][i] = int'(tmp[i*16 +: 16]);
        window_tab[0] = 4;  window_tab[1] = 0;
        cmax_tab[0] = 64'h0000_0000_FFFF_FFFF;
        cmax_tab[1] = 64'd7;

        rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check("reset_state", d, 64'(snap(d)), 64'd0);
        rst = 1'b0;

        // Default window stream, ready held high.
        clear_stream();
        add(1'b1, 16'h0000, 1'b0, 1'b0); add(1'b1, 16'h00E3, 1'b0, 1'b0);
        add(1'b1, 16'h00E3, 1'b0, 1'b0); add(1'b1, 16'h1234, 1'b0, 1'b0);
        add(1'b0, 16'h0000, 1'b1, 1'b0);
        run_meas(0);

        // Same samples with gaps and ready toggling 1,0,0,1.
        clear_stream();
        add(1'b1, 16'h0000, 1'b0, 1'b0); add(1'b0, 16'h0000, 1'b0, 1'b0); add(1'b0, 16'h0000, 1'b0, 1'b0);
        add(1'b1, 16'h00E3, 1'b0, 1'b0); add(1'b0, 16'h0000, 1'b0, 1'b0); add(1'b0, 16'h0000, 1'b0, 1'b0);
        add(1'b1, 16'h00E3, 1'b0, 1'b0); add(1'b0, 16'h0000, 1'b0, 1'b0); add(1'b0, 16'h0000, 1'b0, 1'b0);
        add(1'b1, 16'h1234, 1'b0, 1'b0); add(1'b0, 16'h0000, 1'b1, 1'b0);
        run_meas(1);

        // Saturation: ten 0x0800 with stop alongside the last.
        clear_stream();
        for (int i = 0; i < 10; i++) add(1'b1, 16'h0800, (i == 9), 1'b0);
        run_meas(0);

        // Duplicate bins, start ignored in COUNT, stop with the final sample.
        clear_stream();
        add(1'b1, 16'h0555, 1'b0, 1'b0); add(1'b0, 16'h0000, 1'b0, 1'b1);
        add(1'b1, 16'h0555, 1'b0, 1'b0); add(1'b1, 16'h0555, 1'b1, 1'b0);
        run_meas(1);

        // Randomised streams.
        for (int r = 0; r < 6; r++) begin
            clear_stream();
            len = $urandom_range(4, 30);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 3) != 0) dat = 16'(bins_tab[$urandom_range(0, 1)][$urandom_range(0, NB - 1)]);
                else dat = 16'($urandom);
                add(($urandom_range(0, 2) != 0), dat, (c == len - 1), 1'b0);
            end
            run_meas(r % 3);
        end

        // Reset in the middle of COUNT.
        rdy_mode = 3;
        clear_stream();
        for (int i = 0; i < 3; i++) add(1'b1, 16'h0000, 1'b0, 1'b0);
        drive_stream();
        for (int d = 0; d < 2; d++) check("busy_in_count", d, {63'd0, busy_o[d]}, 64'd1);
        in_valid = 1'b1;
        pulse_reset();
        in_valid = 1'b0;

        // Reset in the middle of a stalled DUMP.
        clear_stream();
        add(1'b1, 16'h0000, 1'b0, 1'b0); add(1'b1, 16'h0000, 1'b0, 1'b0); add(1'b0, 16'h0000, 1'b1, 1'b0);
        drive_stream();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check("stalled_dump", d, {58'd0, busy_o[d], rv_o[d], idx_o[d]}, 64'h30);
        pulse_reset();

        // Fresh measurement after reset.
        clear_stream();
        add(1'b1, 16'h0000, 1'b0, 1'b0); add(1'b1, 16'h0000, 1'b0, 1'b0); add(1'b1, 16'h00E3, 1'b1, 1'b0);
        run_meas(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
